// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Holds the PC and requests one word at a time from instruction memory over a
// req/ack handshake. The returned word is registered as Instr and held until
// the downstream stage retires it. At retire the PC moves to PC+4, or to the
// word-aligned branch target when PCSrc is set. Two sticky flags are kept:
// fetch_err for a memory that never acks, align_err for a misaligned target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        fetch_err,
    output logic        align_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // The last wait cycle tolerated before the fetch is declared dead.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The address bus is simply the current PC; PCPlus8 is the R15 read value.
    assign imem_addr = PC;
    assign PCPlus8   = PC + 32'd8;

    // Fetch state machine with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            PC          <= RESET_PC;
            Instr       <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    imem_req  <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= FETCH;
                end

                FETCH: begin
                    if (imem_ack) begin
                        Instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= HOLD;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Memory gave no answer in the allowed window: park here.
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        state_reg <= ERROR;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                HOLD: begin
                    // Branch inputs only matter at the retire edge.
                    if (instr_ready) begin
                        if (PCSrc) begin
                            PC <= {branch_target[31:2], 2'b00};
                            if (branch_target[1:0] != 2'b00) begin
                                align_err <= 1'b1;
                            end
                        end else begin
                            PC <= PC + 32'd4;
                        end
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= FETCH;
                    end
                end

                ERROR: begin
                    // Only reset leaves this state; the PC stays frozen.
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
